// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, block geometry, scheduler states and the
// small-sigma functions used by message-schedule expansion.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int BLOCK_WORDS = 16;
  localparam int MAX_ROUNDS  = 64;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } sched_state_t;

  // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sha256_s0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sha256_s1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational SHA-256 schedule expansion:
// W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], wrapping mod 2^32.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [31:0] w_m2,
  input  logic [31:0] w_m7,
  input  logic [31:0] w_m15,
  input  logic [31:0] w_m16,
  output logic [31:0] w_new
);

  assign w_new = sha256_s1(w_m2) + w_m7 + sha256_s0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_w_scheduler.sv
// SHA-256 message-schedule producer: loads a 16-word block, then streams W[0..NUM_ROUNDS-1]
// over a valid/ready handshake using a 16-word sliding window.
module sha256_w_scheduler
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_idx,
  output logic        w_last,
  output logic        block_done
);

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  sched_state_t state;
  logic [3:0]   load_cnt;
  logic [5:0]   t;
  logic [31:0]  win [BLOCK_WORDS];
  logic         done_q;
  logic [31:0]  w_new;
  logic         live;
  logic         in_fire;
  logic         w_fire;

  sha256_w_expand u_expand (
    .w_m2  (win[14]),
    .w_m7  (win[9]),
    .w_m15 (win[1]),
    .w_m16 (win[0]),
    .w_new (w_new)
  );

  // Handshake outputs depend only on control state and the gating inputs.
  assign live       = rst & ~abort & ena;
  assign in_ready   = live & (state == LOAD);
  assign w_valid    = live & (state == STREAM);
  assign block_done = live & done_q;

  assign in_fire = in_valid & in_ready;
  assign w_fire  = w_valid & w_ready;

  assign w_data = (t < 6'd16) ? win[t[3:0]] : w_new;
  assign w_idx  = t;
  assign w_last = (t == LAST_T);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= LOAD;
      load_cnt <= 4'd0;
      t        <= 6'd0;
      done_q   <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        win[i] <= 32'd0;
      end
    end else if (abort) begin
      state    <= LOAD;
      load_cnt <= 4'd0;
      t        <= 6'd0;
      done_q   <= 1'b0;
    end else if (ena) begin
      done_q <= w_fire & w_last;
      case (state)
        LOAD: begin
          if (in_fire) begin
            win[load_cnt] <= in_word;
            load_cnt      <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              state <= STREAM;
              t     <= 6'd0;
            end
          end
        end
        STREAM: begin
          if (w_fire) begin
            // First 16 words replay the loaded block; afterwards the window slides.
            if (t >= 6'd16) begin
              for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                win[i] <= win[i + 1];
              end
              win[BLOCK_WORDS - 1] <= w_new;
            end
            if (w_last) begin
              state    <= LOAD;
              load_cnt <= 4'd0;
              t        <= 6'd0;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_w_scheduler.sv
// Directed bench for sha256_w_scheduler: NIST "abc" block, backpressure, enable gaps,
// abort, mid-load reset and back-to-back blocks against an independent schedule model.
module tb_sha256_w_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [5:0]  w_idx;
  logic        w_last;
  logic        block_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] abc_blk [16];
  logic [31:0] blk_b   [16];
  logic [31:0] cur_exp [64];
  logic [31:0] got     [64];

  typedef struct {
    int          t;
    logic [31:0] w;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  sha256_w_scheduler #(.NUM_ROUNDS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .w_idx      (w_idx),
    .w_last     (w_last),
    .block_done (block_done)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_exp(input logic [31:0] b [16]);
    for (int i = 0; i < 16; i++) cur_exp[i] = b[i];
    for (int i = 16; i < 64; i++)
      cur_exp[i] = ss1(cur_exp[i-2]) + cur_exp[i-7] + ss0(cur_exp[i-15]) + cur_exp[i-16];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Feeds words start..15; optional random in_valid gaps, a 5-cycle ena gap at word ena_at,
  // and a 2-cycle reset at word rst_at that forces a full reload.
  task automatic load_block(input logic [31:0] b [16], input int start, input int gap_mode,
                            input int ena_at, input int rst_at);
    int cnt = start;
    int budget = 0;
    bit ena_done = 0;
    bit rst_done = 0;
    while (cnt < 16) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 400) begin
        check("load_timeout", 32'd1, 32'd0);
        return;
      end
      rst = 1'b1; ena = 1'b1; abort = 1'b0; w_ready = 1'b1;
      if (ena_at == cnt && !ena_done) begin
        ena = 1'b0; in_valid = 1'b1; in_word = b[cnt];
        for (int g = 0; g < 5; g++) begin
          if (g > 0) begin @(posedge clk); #1; end
          @(negedge clk);
          check("ena_gap_in_ready", in_ready, 0);
          check("ena_gap_w_valid", w_valid, 0);
        end
        ena_done = 1;
        continue;
      end
      if (rst_at == cnt && !rst_done) begin
        rst = 1'b0; in_valid = 1'b1; in_word = b[cnt];
        for (int g = 0; g < 2; g++) begin
          if (g > 0) begin @(posedge clk); #1; end
          @(negedge clk);
          check("rst_in_ready", in_ready, 0);
          check("rst_w_valid", w_valid, 0);
          check("rst_block_done", block_done, 0);
        end
        rst_done = 1;
        cnt = 0;
        continue;
      end
      in_valid = gap_mode != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_word  = in_valid ? b[cnt] : (32'hBAD0_0000 | 32'(cnt));
      @(negedge clk);
      check("load_in_ready", in_ready, 1);
      check("load_w_valid", w_valid, 0);
      check("load_block_done", block_done, 0);
      if (in_valid && in_ready) cnt++;
    end
  endtask

  // Consumes the stream and compares against cur_exp; optional random backpressure,
  // 5-cycle ena gap at t=ena_at, abort at t=abort_at. btb keeps in_valid high with btb_word.
  task automatic stream_block(input int rmode, input int ena_at, input int abort_at,
                              input bit btb, input logic [31:0] btb_word);
    int k = 0;
    int budget = 0;
    bit stalled = 0;
    bit first = 1;
    bit ena_done = 0;
    logic [31:0] hold_d = '0;
    logic [5:0]  hold_i = '0;
    while (k < 64) begin
      @(posedge clk); #1;
      budget++;
      if (budget > 1000) begin
        check("stream_timeout", 32'd1, 32'd0);
        return;
      end
      rst = 1'b1; abort = 1'b0; ena = 1'b1;
      in_valid = btb; in_word = btb_word;
      if (abort_at == k) begin
        abort = 1'b1; w_ready = 1'b1;
        @(negedge clk);
        check("abort_w_valid", w_valid, 0);
        check("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_abort_w_valid", w_valid, 0);
        check("post_abort_in_ready", in_ready, 1);
        check("post_abort_idx", 32'(w_idx), 0);
        return;
      end
      if (ena_at == k && !ena_done) begin
        ena = 1'b0; w_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
          if (g > 0) begin @(posedge clk); #1; end
          @(negedge clk);
          check("ena_gap_w_valid", w_valid, 0);
          check("ena_gap_in_ready", in_ready, 0);
        end
        ena_done = 1;
        stalled = 0;
        continue;
      end
      w_ready = rmode != 0 ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (first) check("first_w_latency", w_valid, 1);
      first = 0;
      check("stream_w_valid", w_valid, 1);
      check("stream_in_ready", in_ready, 0);
      check("stream_block_done", block_done, 0);
      if (stalled) begin
        check("stall_data", w_data, hold_d);
        check("stall_idx", 32'(w_idx), 32'(hold_i));
      end
      check("w_idx", 32'(w_idx), 32'(k));
      check($sformatf("w_data_t%0d", k), w_data, cur_exp[k]);
      check("w_last", w_last, (k == 63) ? 1 : 0);
      got[k] = w_data;
      stalled = w_valid && !w_ready;
      hold_d = w_data;
      hold_i = w_idx;
      if (w_valid && w_ready) k++;
    end
    @(posedge clk); #1;
    in_valid = btb; in_word = btb_word; w_ready = 1'b1; ena = 1'b1;
    @(negedge clk);
    check("block_done", block_done, 1);
    check("done_in_ready", in_ready, 1);
    check("done_w_valid", w_valid, 0);
  endtask

  initial begin
    abc_blk[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) abc_blk[i] = 32'h0;
    abc_blk[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) blk_b[i] = (32'h01010101 * i) ^ 32'hDEADBEEF;

    tbl[0] = '{0,  32'h61626380};
    tbl[1] = '{1,  32'h00000000};
    tbl[2] = '{14, 32'h00000000};
    tbl[3] = '{15, 32'h00000018};
    tbl[4] = '{16, 32'h61626380};
    tbl[5] = '{17, 32'h000F0000};
    tbl[6] = '{63, 32'h12B1EDEB};

    rst = 1'b0; ena = 1'b1; abort = 1'b0;
    in_valid = 1'b0; in_word = 32'h0; w_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_w_valid", w_valid, 0);
    check("reset_block_done", block_done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_w_idx", 32'(w_idx), 0);
    check("post_reset_w_valid", w_valid, 0);

    // NIST "abc", w_ready held high
    build_exp(abc_blk);
    load_block(abc_blk, 0, 0, -1, -1);
    stream_block(0, -1, -1, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++)
      check($sformatf("abc_W%0d", tbl[i].t), got[tbl[i].t], tbl[i].w);

    // Backpressure and in_valid gaps
    load_block(abc_blk, 0, 1, -1, -1);
    stream_block(1, -1, -1, 1'b0, 32'h0);

    // ena gaps at load_cnt=7 and t=20
    load_block(abc_blk, 0, 0, 7, -1);
    stream_block(0, 20, -1, 1'b0, 32'h0);

    // abort at t=30, then a fresh block
    load_block(abc_blk, 0, 0, -1, -1);
    stream_block(0, -1, 30, 1'b0, 32'h0);
    load_block(abc_blk, 0, 0, -1, -1);
    stream_block(0, -1, -1, 1'b0, 32'h0);

    // reset at load_cnt=9, then full reload
    load_block(abc_blk, 0, 0, -1, 9);
    stream_block(0, -1, -1, 1'b0, 32'h0);

    // Back-to-back blocks: block B word 0 accepted in the block_done cycle
    load_block(abc_blk, 0, 0, -1, -1);
    stream_block(0, -1, -1, 1'b1, blk_b[0]);
    build_exp(blk_b);
    load_block(blk_b, 1, 0, -1, -1);
    stream_block(0, -1, -1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
